// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame states, parity modes and bit timing helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int cycles_per_bit(input int half_period);
    return 2 * half_period;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-slot counter producing end-of-bit and mid-bit strobes
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int p_BITSLOT_HALF_PERIOD = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_bit_end,
  output logic o_bit_mid
);

  localparam int CYCLES = cycles_per_bit(p_BITSLOT_HALF_PERIOD);
  localparam int CNT_W  = ($clog2(CYCLES) < 1) ? 1 : $clog2(CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] MID  = CNT_W'(p_BITSLOT_HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // Restart realigns the slot so the cycle after a restart is slot cycle 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_bit_end = (cnt == LAST);
  assign o_bit_mid = (cnt == MID);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: valid/ready word in, LSB-first serial frame out
module uart_tx
  import uart_pkg::*;
#(
  parameter int p_BITSLOT_HALF_PERIOD = 1,
  parameter int p_DATA_BITS           = 8,
  parameter int p_STOP_BITS           = 1,
  parameter int p_PARITY              = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [p_DATA_BITS-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_busy
);

  localparam int IDX_MAX = (p_DATA_BITS > p_STOP_BITS) ? p_DATA_BITS : p_STOP_BITS;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);

  generate
    if (p_PARITY != PARITY_NONE && p_PARITY != PARITY_ODD && p_PARITY != PARITY_EVEN) begin : g_bad_parity
      $error("uart_tx: p_PARITY must be 0, 1 or 2");
    end
    if (p_DATA_BITS < 1 || p_DATA_BITS > 16) begin : g_bad_data_bits
      $error("uart_tx: p_DATA_BITS must be in 1..16");
    end
    if (p_STOP_BITS < 1) begin : g_bad_stop_bits
      $error("uart_tx: p_STOP_BITS must be at least 1");
    end
  endgenerate

  uart_state_e            state, state_next;
  logic [p_DATA_BITS-1:0] shift, shift_next;
  logic [IDX_W-1:0]       idx;
  logic                   par_bit;
  logic                   tx_next;
  logic                   bit_end;
  logic                   timer_mid_unused;
  logic                   accept;
  logic                   last_data;
  logic                   last_stop;

  assign accept    = i_valid && o_ready;
  assign last_data = (idx == IDX_W'(p_DATA_BITS - 1));
  assign last_stop = (idx == IDX_W'(p_STOP_BITS - 1));

  uart_bit_timer #(
    .p_BITSLOT_HALF_PERIOD(p_BITSLOT_HALF_PERIOD)
  ) u_bit_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_restart(accept),
    .o_bit_end(bit_end),
    .o_bit_mid(timer_mid_unused)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = ST_START;
      ST_START:  if (bit_end) state_next = ST_DATA;
      ST_DATA:   if (bit_end && last_data)
                   state_next = (p_PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (bit_end) state_next = ST_STOP;
      ST_STOP:   if (bit_end && last_stop) state_next = accept ? ST_START : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Line level is derived from the next state so o_tx can be registered without lag.
  always_comb begin
    o_ready    = (state == ST_IDLE) || (state == ST_STOP && bit_end && last_stop);
    shift_next = shift;
    if (accept) begin
      shift_next = i_data;
    end else if (state == ST_DATA && bit_end) begin
      shift_next = shift >> 1;
    end
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = par_bit;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift   <= '0;
      idx     <= '0;
      par_bit <= 1'b0;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      shift  <= shift_next;
      o_tx   <= tx_next;
      o_busy <= (state_next != ST_IDLE);
      if (accept) begin
        par_bit <= (p_PARITY == PARITY_ODD) ? ~^i_data : ^i_data;
      end
      if (state_next != state) begin
        idx <= '0;
      end else if (bit_end && (state == ST_DATA || state == ST_STOP)) begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
